// File: rtl/command_scheduler.sv
// command_scheduler
//   Round-robin scheduler that writes packet-builder commands into the command
//   FIFO, one command per cycle while the FIFO has room.
//   Each stream has a frame template, a packet budget and a minimum gap
//   between its own grants. All config is snapshotted on start.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start with at least one stream enabled
//   RUN   | arbitrating streams and writing commands until finished or stop
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start, stop         scheduling control pulses
//   cfg_*               per-stream config, packed (stream k in slice k)
//   fifo_full           FIFO backpressure
//   fifo_wr_enable      combinational write strobe
//   fifo_*              command fields of the granted stream
//   busy, done          RUN indicator, one-cycle pulse on RUN->IDLE
//   total_sent          commands written since the last start (wraps)
module command_scheduler #(
    parameter int N_STREAMS   = 4,
    parameter int COUNT_WIDTH = 32,
    parameter int GAP_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             stop,
    input  logic [N_STREAMS-1:0]             cfg_enable,
    input  logic [N_STREAMS*11-1:0]          cfg_size,
    input  logic [N_STREAMS*48-1:0]          cfg_d_mac,
    input  logic [N_STREAMS*48-1:0]          cfg_s_mac,
    input  logic [N_STREAMS*16-1:0]          cfg_ethertype,
    input  logic [N_STREAMS*8-1:0]           cfg_payload,
    input  logic [N_STREAMS*COUNT_WIDTH-1:0] cfg_count,
    input  logic [N_STREAMS*GAP_WIDTH-1:0]   cfg_gap,
    input  logic                             fifo_full,
    output logic                             fifo_wr_enable,
    output logic [10:0]                      fifo_size,
    output logic [47:0]                      fifo_d_mac,
    output logic [47:0]                      fifo_s_mac,
    output logic [15:0]                      fifo_ethertype,
    output logic [7:0]                       fifo_payload,
    output logic                             busy,
    output logic                             done,
    output logic [COUNT_WIDTH-1:0]           total_sent
);

    localparam int PW = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]             state;
    logic [PW-1:0]          ptr;
    logic [N_STREAMS-1:0]   snap_en;
    logic [N_STREAMS-1:0]   snap_fin;     // 1 = finite budget (cfg_count != 0)
    logic [10:0]            snap_size      [N_STREAMS];
    logic [47:0]            snap_d_mac     [N_STREAMS];
    logic [47:0]            snap_s_mac     [N_STREAMS];
    logic [15:0]            snap_ethertype [N_STREAMS];
    logic [7:0]             snap_payload   [N_STREAMS];
    logic [GAP_WIDTH-1:0]   snap_gap       [N_STREAMS];
    logic [COUNT_WIDTH-1:0] remaining      [N_STREAMS];
    logic [GAP_WIDTH-1:0]   gap_timer      [N_STREAMS];

    logic [N_STREAMS-1:0]   elig;
    logic [PW-1:0]          grant;
    logic                   found;
    logic [PW:0]            idx_sum;
    logic [PW-1:0]          sel;
    logic                   all_fin_next;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (v == PW'(N_STREAMS - 1)) return '0;
        return v + 1'b1;
    endfunction

    always_comb begin
        for (int k = 0; k < N_STREAMS; k++) begin
            elig[k] = snap_en[k] && (gap_timer[k] == '0) &&
                      (!snap_fin[k] || (remaining[k] != '0));
        end
    end

    // First eligible stream at or above the pointer, wrapping around.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        idx_sum = '0;
        for (int i = 0; i < N_STREAMS; i++) begin
            idx_sum = {1'b0, ptr} + (PW+1)'(i);
            if (idx_sum >= (PW+1)'(N_STREAMS)) idx_sum = idx_sum - (PW+1)'(N_STREAMS);
            if (!found && elig[idx_sum[PW-1:0]]) begin
                found = 1'b1;
                grant = idx_sum[PW-1:0];
            end
        end
    end

    assign fifo_wr_enable = (state == RUN) && !stop && !fifo_full && found;
    assign sel            = fifo_wr_enable ? grant : '0;
    assign fifo_size      = snap_size[sel];
    assign fifo_d_mac     = snap_d_mac[sel];
    assign fifo_s_mac     = snap_s_mac[sel];
    assign fifo_ethertype = snap_ethertype[sel];
    assign fifo_payload   = snap_payload[sel];
    assign busy           = (state == RUN);

    // Looks through this cycle's write so RUN ends on the edge of the last write.
    always_comb begin
        all_fin_next = 1'b1;
        for (int k = 0; k < N_STREAMS; k++) begin
            if (snap_en[k]) begin
                if (!snap_fin[k]) begin
                    all_fin_next = 1'b0;
                end else if ((remaining[k] != '0) &&
                             !(fifo_wr_enable && (grant == PW'(k)) &&
                               (remaining[k] == COUNT_WIDTH'(1)))) begin
                    all_fin_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            done       <= 1'b0;
            total_sent <= '0;
            snap_en    <= '0;
            snap_fin   <= '0;
            for (int k = 0; k < N_STREAMS; k++) begin
                snap_size[k]      <= '0;
                snap_d_mac[k]     <= '0;
                snap_s_mac[k]     <= '0;
                snap_ethertype[k] <= '0;
                snap_payload[k]   <= '0;
                snap_gap[k]       <= '0;
                remaining[k]      <= '0;
                gap_timer[k]      <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (cfg_enable != '0)) begin
                        state      <= RUN;
                        ptr        <= '0;
                        total_sent <= '0;
                        snap_en    <= cfg_enable;
                        for (int k = 0; k < N_STREAMS; k++) begin
                            snap_size[k]      <= cfg_size[k*11 +: 11];
                            snap_d_mac[k]     <= cfg_d_mac[k*48 +: 48];
                            snap_s_mac[k]     <= cfg_s_mac[k*48 +: 48];
                            snap_ethertype[k] <= cfg_ethertype[k*16 +: 16];
                            snap_payload[k]   <= cfg_payload[k*8 +: 8];
                            snap_gap[k]       <= cfg_gap[k*GAP_WIDTH +: GAP_WIDTH];
                            snap_fin[k]       <= (cfg_count[k*COUNT_WIDTH +: COUNT_WIDTH] != '0);
                            remaining[k]      <= cfg_count[k*COUNT_WIDTH +: COUNT_WIDTH];
                            gap_timer[k]      <= '0;
                        end
                    end
                end
                default: begin
                    if (fifo_wr_enable) begin
                        ptr        <= wrap_inc(grant);
                        total_sent <= total_sent + 1'b1;
                    end
                    for (int k = 0; k < N_STREAMS; k++) begin
                        if (fifo_wr_enable && (grant == PW'(k))) begin
                            gap_timer[k] <= snap_gap[k];
                            if (snap_fin[k]) remaining[k] <= remaining[k] - 1'b1;
                        end else if (gap_timer[k] != '0) begin
                            gap_timer[k] <= gap_timer[k] - 1'b1;
                        end
                    end
                    if (stop || all_fin_next) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
